// File: rtl/fp_pkg.sv
// Shared definitions for the binary32 subtract scheduler.
//   FP_W / EXP_MSB / EXP_LSB : binary32 field geometry
//   QNAN                     : canonical quiet NaN returned on unsupported operands
//   sched_state_t            : scheduler FSM states
//   is_special()             : flags zero/subnormal (exp 00) and inf/NaN (exp FF)
package fp_pkg;
  localparam int unsigned FP_W    = 32;
  localparam int unsigned EXP_MSB = 30;
  localparam int unsigned EXP_LSB = 23;
  localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} sched_state_t;

  function automatic logic is_special(input logic [FP_W-1:0] x);
    return (x[EXP_MSB:EXP_LSB] == 8'h00) || (x[EXP_MSB:EXP_LSB] == 8'hFF);
  endfunction
endpackage

// File: rtl/fp_rr_arb.sv
// Combinational rotating-priority arbiter.
//   req     : request vector
//   ptr     : index of the last winner; search starts at ptr+1 and wraps
//   en      : arbitration enable; no grant when low
//   gnt     : one-hot grant
//   gnt_idx : encoded index of the grant (0 when no grant)
module fp_rr_arb
  import fp_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);
  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IW'((32'(ptr) + k) % NREQ);
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end
endmodule

// File: rtl/fp_sub_sched.sv
// Shares one external combinational binary32 subtract datapath among NREQ
// requesters: round-robin grant, operand latch, fixed DP_LAT wait, tagged
// result with output backpressure.
//   req_valid/req_ready : per-requester handshake (ready is a one-hot strobe)
//   req_a/req_b         : packed operands, requester i at [32*i +: 32]
//   resp_*              : result, requester tag, unsupported-operand flag
//   dp_a/dp_b/dp_c      : registered operands to, and result from, the datapath
//   busy                : scheduler not idle
module fp_sub_sched
  import fp_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DP_LAT = 1,
  localparam int unsigned IW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*FP_W-1:0] req_a,
  input  logic [NREQ*FP_W-1:0] req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [FP_W-1:0]      resp_data,
  output logic [IW-1:0]        resp_id,
  output logic                 resp_exc,
  output logic [FP_W-1:0]      dp_a,
  output logic [FP_W-1:0]      dp_b,
  input  logic [FP_W-1:0]      dp_c,
  output logic                 busy
);
  sched_state_t    state;
  logic [IW-1:0]   rr_ptr;
  logic [2:0]      cnt;
  logic            accept;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gidx;
  logic [FP_W-1:0] ga, gb;

  // Reset gates the arbiter so no accept strobe is shown while rst_n is low.
  assign accept    = rst_n && ((state == IDLE) || ((state == RESP) && resp_ready));
  assign req_ready = gnt;
  assign busy      = (state != IDLE);

  fp_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .en      (accept),
    .gnt     (gnt),
    .gnt_idx (gidx)
  );

  always_comb begin
    ga = '0;
    gb = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gidx == IW'(i)) begin
        ga = req_a[i*FP_W +: FP_W];
        gb = req_b[i*FP_W +: FP_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= IW'(NREQ-1);
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_exc   <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      dp_a       <= '0;
      dp_b       <= '0;
    end else begin
      case (state)
        EXEC: begin
          if (cnt == 3'(DP_LAT-1)) begin
            resp_data  <= dp_c;
            resp_exc   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        IDLE, RESP: begin
          if (accept) begin
            if (|gnt) begin
              dp_a    <= ga;
              dp_b    <= gb;
              resp_id <= gidx;
              rr_ptr  <= gidx;
              if (is_special(ga) || is_special(gb)) begin
                state      <= RESP;
                resp_valid <= 1'b1;
                resp_exc   <= 1'b1;
                resp_data  <= QNAN;
              end else if (ga == gb) begin
                state      <= RESP;
                resp_valid <= 1'b1;
                resp_exc   <= 1'b0;
                resp_data  <= '0;
              end else begin
                state      <= EXEC;
                cnt        <= '0;
                resp_valid <= 1'b0;
                resp_exc   <= 1'b0;
              end
            end else begin
              state      <= IDLE;
              resp_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_sub_sched.sv
module tb_fp_sub_sched;
  import fp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT with DP_LAT=1
  logic         rst_n;
  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_a, req_b;
  logic         resp_valid, resp_ready, resp_exc, busy;
  logic [31:0]  resp_data, dp_a, dp_b, dp_c;
  logic [1:0]   resp_id;

  // DUT with DP_LAT=4
  logic         rst4_n;
  logic [3:0]   req_valid4, req_ready4;
  logic [127:0] req_a4, req_b4;
  logic         resp_valid4, resp_ready4, resp_exc4, busy4;
  logic [31:0]  resp_data4, dp_a4, dp_b4, dp_c4;
  logic [1:0]   resp_id4;

  fp_sub_sched #(.NREQ(4), .DP_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .resp_exc(resp_exc),
    .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .busy(busy));

  fp_sub_sched #(.NREQ(4), .DP_LAT(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_a(req_a4), .req_b(req_b4), .resp_valid(resp_valid4), .resp_ready(resp_ready4),
    .resp_data(resp_data4), .resp_id(resp_id4), .resp_exc(resp_exc4),
    .dp_a(dp_a4), .dp_b(dp_b4), .dp_c(dp_c4), .busy(busy4));

  // Datapath model: binary32 a-b via double precision, rounded to nearest-even.
  function automatic real f2r(input logic [31:0] x);
    if (x[30:23] == 8'h00) return 0.0;
    return $bitstoreal({x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] r2f(input real d);
    logic [63:0] q;
    logic [30:0] em;
    int e;
    q = $realtobits(d);
    if (q[62:0] == 63'd0) return {q[63], 31'b0};
    e  = int'(q[62:52]) - 896;
    em = {8'(e), q[51:29]};
    if (q[28] && ((|q[27:0]) || q[29])) em = em + 31'd1;
    return {q[63], em};
  endfunction

  function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) - f2r(b));
  endfunction

  assign dp_c  = fsub(dp_a, dp_b);
  assign dp_c4 = fsub(dp_a4, dp_b4);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Transaction-level reference model of the scheduler (DP_LAT=1 instance)
  localparam int LAT = 1;
  int          m_ptr, m_left, cyc;
  bit          m_valid, m_exc;
  logic [31:0] m_data, m_pend, m_dpa, m_dpb;
  int          m_id;
  int          glog[$];
  int          gcyc[$];

  task automatic model_reset();
    m_ptr = 3; m_left = 0; m_valid = 0; m_exc = 0;
    m_data = '0; m_pend = '0; m_dpa = '0; m_dpb = '0; m_id = 0;
  endtask

  // Called just after a falling edge with inputs already driven. Predicts the
  // accept strobe, advances one rising edge, then checks registered outputs.
  task automatic tick();
    int g;
    bit acc;
    logic [3:0]  exp_rdy;
    logic [31:0] a, b;
    acc = (m_left == 0) && (!m_valid || resp_ready);
    g = -1;
    if (acc)
      for (int k = 1; k <= 4; k++)
        if (g < 0 && req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
    #1 check("req_ready", {28'b0, req_ready}, {28'b0, exp_rdy});
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_valid = 1; m_data = m_pend; m_exc = 0; end
    end else if (acc) begin
      if (g < 0) m_valid = 0;
      else begin
        a = req_a[32*g +: 32];
        b = req_b[32*g +: 32];
        m_dpa = a; m_dpb = b; m_ptr = g; m_id = g;
        glog.push_back(g);
        gcyc.push_back(cyc);
        if (a[30:23] == 8'h00 || a[30:23] == 8'hFF || b[30:23] == 8'h00 || b[30:23] == 8'hFF) begin
          m_valid = 1; m_exc = 1; m_data = 32'h7FC0_0000;
        end else if (a == b) begin
          m_valid = 1; m_exc = 0; m_data = 32'h0;
        end else begin
          m_valid = 0; m_left = LAT; m_pend = fsub(a, b);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("resp_valid", {31'b0, resp_valid}, {31'b0, m_valid});
    check("busy", {31'b0, busy}, {31'b0, (m_valid || m_left > 0)});
    check("dp_a", dp_a, m_dpa);
    check("dp_b", dp_b, m_dpb);
    if (m_valid) begin
      check("resp_data", resp_data, m_data);
      check("resp_id", {30'b0, resp_id}, 32'(m_id));
      check("resp_exc", {31'b0, resp_exc}, {31'b0, m_exc});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 4'hF; resp_ready = 1'b0;
    model_reset();
    #1;
    check("rst_req_ready", {28'b0, req_ready}, 32'h0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    e = 8'($urandom_range(135, 120));
    if ($urandom_range(15, 0) == 0) e = ($urandom_range(1, 0) == 1) ? 8'hFF : 8'h00;
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  initial begin
    logic [31:0] held;
    int lat;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    rst4_n = 1'b0; req_valid4 = '0; req_a4 = '0; req_b4 = '0; resp_ready4 = 1'b0;
    cyc = 0;

    // Reset with every requester valid; req0 must win first after release
    do_reset();
    req_valid = 4'b0001;
    req_a[31:0] = 32'h4290_0000;  // 72.0
    req_b[31:0] = 32'h4070_0000;  // 3.75
    resp_ready = 1'b1;
    tick();
    req_valid = 4'b0000;
    tick();
    check("single_data", resp_data, 32'h4288_8000);  // 68.25
    check("single_id", {30'b0, resp_id}, 32'h0);
    tick();

    // Equality bypass, then exception, both visible one cycle after accept
    req_valid = 4'b0100;
    req_a[64 +: 32] = 32'h3F80_0000;
    req_b[64 +: 32] = 32'h3F80_0000;
    tick();
    check("bypass_valid", {31'b0, resp_valid}, 32'h1);
    check("bypass_data", resp_data, 32'h0);
    check("bypass_exc", {31'b0, resp_exc}, 32'h0);
    req_b[64 +: 32] = 32'h7F80_0000;
    tick();
    check("exc_flag", {31'b0, resp_exc}, 32'h1);
    check("exc_data", resp_data, 32'h7FC0_0000);
    req_valid = 4'b0000;
    tick();

    // Backpressure: response held five cycles while req1 waits
    req_valid = 4'b0001;
    req_a[31:0] = 32'h4120_0000;
    req_b[31:0] = 32'h3F80_0000;
    tick();
    req_valid = 4'b0010;
    req_a[63:32] = 32'h4040_0000;
    req_b[63:32] = 32'h3F00_0000;
    resp_ready = 1'b0;
    tick();
    held = resp_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold", resp_data, held);
    end
    resp_ready = 1'b1;
    #1 check("bp_accept_same_cycle", {28'b0, req_ready}, 32'h2);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();

    // Round robin with all four valid: order 0,1,2,3,0 at DP_LAT+1 spacing
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = 32'h4100_0000 + (i << 20);
      req_b[32*i +: 32] = 32'h3F80_0000;
    end
    req_valid = 4'hF;
    resp_ready = 1'b1;
    glog.delete();
    gcyc.delete();
    for (int i = 0; i < 10; i++) tick();
    check("rr_count", 32'(glog.size()), 32'd5);
    if (glog.size() >= 5) begin
      check("rr_g0", 32'(glog[0]), 32'd0);
      check("rr_g1", 32'(glog[1]), 32'd1);
      check("rr_g2", 32'(glog[2]), 32'd2);
      check("rr_g3", 32'(glog[3]), 32'd3);
      check("rr_g4", 32'(glog[4]), 32'd0);
      for (int i = 1; i < 5; i++)
        check("rr_interval", 32'(gcyc[i] - gcyc[i-1]), 32'(LAT + 1));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      req_valid  = 4'($urandom);
      resp_ready = ($urandom_range(3, 0) != 0);
      for (int r = 0; r < 4; r++) begin
        req_a[32*r +: 32] = rnd_fp();
        req_b[32*r +: 32] = ($urandom_range(7, 0) == 0) ? req_a[32*r +: 32] : rnd_fp();
      end
      tick();
    end
    req_valid = '0;

    // Mid-operation reset on the DP_LAT=4 instance
    @(negedge clk);
    rst4_n = 1'b1;
    resp_ready4 = 1'b1;
    req_valid4 = 4'b0100;
    req_a4[64 +: 32] = 32'h4120_0000;
    req_b4[64 +: 32] = 32'h3F80_0000;
    #1 check("l4_ready", {28'b0, req_ready4}, 32'h4);
    @(negedge clk);
    req_valid4 = '0;
    check("l4_busy_exec", {31'b0, busy4}, 32'h1);
    @(negedge clk);
    check("l4_no_resp_yet", {31'b0, resp_valid4}, 32'h0);
    rst4_n = 1'b0;
    #1;
    check("l4_rst_busy", {31'b0, busy4}, 32'h0);
    check("l4_rst_valid", {31'b0, resp_valid4}, 32'h0);
    check("l4_rst_dpa", dp_a4, 32'h0);
    @(negedge clk);
    rst4_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("l4_no_stale", {31'b0, resp_valid4}, 32'h0);
    end

    // Normal latency on DP_LAT=4: accept in cycle 0 -> resp_valid in cycle 5
    req_valid4 = 4'b0010;
    req_a4[63:32] = 32'h4120_0000;  // 10.0
    req_b4[63:32] = 32'h3F80_0000;  // 1.0
    lat = 0;
    @(negedge clk);
    req_valid4 = '0;
    lat = 1;
    while (!resp_valid4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("l4_latency", 32'(lat), 32'd5);
    check("l4_data", resp_data4, 32'h4110_0000);  // 9.0
    check("l4_id", {30'b0, resp_id4}, 32'h1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
